// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
// Loader states plus word and byte sizing.
package prog_loader_pkg;

  localparam int MAX_WORDS = 64;
  localparam int BYTE_W    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/loader_cksum.sv
// Running XOR over every framed byte of a load.
// Cleared when a load starts, advanced on each covered byte.
module loader_cksum
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [BYTE_W-1:0] o_sum
);

  logic [BYTE_W-1:0] r_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_sum <= '0;
    else if (i_clr)
      r_sum <= '0;
    else if (i_en)
      r_sum <= r_sum ^ i_byte;
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader for the 64x16 processor memory.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADRS_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADRS_W-1:0] mem_adrs,
  output logic [DATA_W-1:0] mem_din,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(MAX_WORDS) + 1;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_wcnt;
  logic [ADRS_W-1:0] r_adrs;
  logic [DATA_W-1:0] r_din;
  logic              r_hold;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              w_acc;
  logic              w_cnt_ok;
  logic              w_last;
  logic              w_go;

  assign w_go     = (r_state == S_IDLE) && start;
  assign w_acc    = rx_valid && rx_ready;
  assign w_cnt_ok = (rx_data != '0) &&
                    (rx_data <= BYTE_W'(MAX_WORDS));
  assign w_last   = (r_wcnt + CNT_W'(1)) == r_cnt;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] w_sum;
  logic              w_ck_en;

  // The checksum byte itself is compared, not accumulated.
  assign w_ck_en = w_acc && (r_state != S_CHK);

  loader_cksum u_cksum (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_go),
    .i_en   (w_ck_en),
    .i_byte (rx_data),
    .o_sum  (w_sum)
  );

  assign rx_ready = (r_state == S_COUNT) || (r_state == S_HI) ||
                    (r_state == S_LO)    || (r_state == S_CHK);
`else
  assign rx_ready = (r_state == S_COUNT) || (r_state == S_HI) ||
                    (r_state == S_LO);
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_COUNT;
      S_COUNT: if (w_acc) w_next = w_cnt_ok ? S_HI : S_ERR;
      S_HI:    if (w_acc) w_next = S_LO;
      S_LO:    if (w_acc) w_next = S_WRITE;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_WRITE: w_next = w_last ? S_CHK : S_HI;
      S_CHK:   if (w_acc) w_next = (rx_data == w_sum) ? S_DONE : S_ERR;
`else
      S_WRITE: w_next = w_last ? S_DONE : S_HI;
`endif
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wcnt  <= '0;
      r_adrs  <= '0;
      r_din   <= '0;
      r_hold  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start) begin
          r_hold <= 1'b1;
          r_busy <= 1'b1;
          r_done <= 1'b0;
          r_err  <= 1'b0;
          r_adrs <= '0;
          r_wcnt <= '0;
        end
        S_COUNT: if (w_acc) r_cnt <= rx_data[CNT_W-1:0];
        S_HI: if (w_acc) r_din[DATA_W-1 -: BYTE_W] <= rx_data;
        S_LO: if (w_acc) r_din[BYTE_W-1:0] <= rx_data;
        S_WRITE: begin
          r_wcnt <= r_wcnt + CNT_W'(1);
          // Last address is kept so it is visible after the load.
          if (!w_last) r_adrs <= r_adrs + ADRS_W'(1);
        end
        S_DONE: begin
          r_hold <= 1'b0;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        S_ERR: begin
          r_hold <= 1'b0;
          r_busy <= 1'b0;
          r_err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_we   = (r_state == S_WRITE);
  assign mem_adrs = r_adrs;
  assign mem_din  = r_din;
  assign cpu_hold = r_hold;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized bench for prog_loader.
// Framed streams are built from a queue model of expected writes.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        mem_we;
  logic [5:0]  mem_adrs;
  logic [15:0] mem_din;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  prog_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .mem_we   (mem_we),
    .mem_adrs (mem_adrs),
    .mem_din  (mem_din),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nerr = 0;
  int          n_wr = 0;
  logic [15:0] mem_img [64];
  logic [21:0] exp_q [$];
  logic [15:0] wq [$];
  logic [21:0] e_wr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && mem_we === 1'b1) begin
      n_wr++;
      mem_img[mem_adrs] = mem_din;
      chk("hold_in_write", {31'd0, cpu_hold}, 32'd1);
      nvec++;
      assert (exp_q.size() != 0) else begin
        nerr++;
        $error("FAIL spurious_write: observed %0h:%0h expected none",
               mem_adrs, mem_din);
      end
      if (exp_q.size() != 0) begin
        e_wr = exp_q.pop_front();
        chk("write", {10'd0, mem_adrs, mem_din}, {10'd0, e_wr});
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    chk({tag, "_mem_we"},   {31'd0, mem_we},   32'd0);
    chk({tag, "_mem_adrs"}, {26'd0, mem_adrs}, 32'd0);
    chk({tag, "_mem_din"},  {16'd0, mem_din},  32'd0);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_busy"},     {31'd0, busy},     32'd0);
    chk({tag, "_done"},     {31'd0, done},     32'd0);
    chk({tag, "_err"},      {31'd0, err},      32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit thr);
    bit ok = 1'b0;
    int n = 0;
    while (!ok && n < 400) begin
      @(negedge clk);
      rx_data  = b;
      rx_valid = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      ok = rx_valid && rx_ready;
      n++;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
    end
    chk("byte_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] cnt, input bit thr,
                          input bit bad_ck, input bit poke);
    logic [7:0] q [$];
    logic [7:0] x;
    bit         valid;
    bit         good;
    int         n;
    int         wr0;
    valid = (cnt >= 8'd1) && (cnt <= 8'd64);
    good  = valid;
    q.push_back(cnt);
    if (valid) begin
      foreach (wq[i]) begin
        q.push_back(wq[i][15:8]);
        q.push_back(wq[i][7:0]);
        exp_q.push_back({6'(i), wq[i]});
      end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    if (valid) begin
      x = 8'h00;
      foreach (q[i]) x ^= q[i];
      q.push_back(bad_ck ? (x ^ 8'h01) : x);
      good = !bad_ck;
    end
`endif
    wr0 = n_wr;
    pulse_start();
    chk("hold_rise", {31'd0, cpu_hold}, 32'd1);
    chk("busy_rise", {31'd0, busy}, 32'd1);
    chk("done_clr",  {31'd0, done}, 32'd0);
    chk("adrs_clr",  {26'd0, mem_adrs}, 32'd0);
    foreach (q[i]) begin
      if (poke && i == 1) start = 1'b1;
      send_byte(q[i], thr);
      start = 1'b0;
    end
    if (!valid) begin
      @(negedge clk);
      chk("bad_err_t1",  {31'd0, err}, 32'd0);
      chk("bad_hold_t1", {31'd0, cpu_hold}, 32'd1);
      @(negedge clk);
      chk("bad_err_t2",  {31'd0, err}, 32'd1);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done || err) && n < 300);
    chk("done",      {31'd0, done}, {31'd0, good});
    chk("err",       {31'd0, err},  {31'd0, !good});
    chk("hold_fall", {31'd0, cpu_hold}, 32'd0);
    chk("busy_fall", {31'd0, busy}, 32'd0);
    chk("ready_idle", {31'd0, rx_ready}, 32'd0);
    chk("writes_left", exp_q.size(), 32'd0);
    chk("write_count", n_wr - wr0, valid ? {24'd0, cnt} : 32'd0);
    chk("adrs_last", {26'd0, mem_adrs},
        valid ? {24'd0, cnt - 8'd1} : 32'd0);
  endtask

  initial begin
    logic [7:0] c;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    wq = '{16'h1234, 16'hABCD};
    run_load(8'h02, 1'b0, 1'b0, 1'b0);
    chk("mem0_norm", {16'd0, mem_img[0]}, 32'h1234);
    chk("mem1_norm", {16'd0, mem_img[1]}, 32'hABCD);

    wq.delete();
    run_load(8'h00, 1'b0, 1'b0, 1'b0);
    run_load(8'h41, 1'b0, 1'b0, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
    wq = '{16'h1234, 16'hABCD};
    run_load(8'h02, 1'b0, 1'b1, 1'b0);
`endif

    wq.delete();
    for (int i = 0; i < 64; i++) wq.push_back(16'($urandom));
    run_load(8'h40, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++)
      chk("mem_full", {16'd0, mem_img[i]}, {16'd0, wq[i]});

    for (int k = 0; k < 3; k++) begin
      c = 8'($urandom_range(1, 64));
      wq.delete();
      for (int i = 0; i < int'(c); i++) wq.push_back(16'($urandom));
      run_load(c, k[0], 1'b0, 1'b0);
    end

    wq = '{16'h0F0F, 16'hF00D, 16'h1357};
    run_load(8'h03, 1'b0, 1'b0, 1'b1);

    wq.delete();
    for (int i = 0; i < 5; i++) wq.push_back(16'($urandom) | 16'h0101);
    for (int i = 0; i < 3; i++) exp_q.push_back({6'(i), wq[i]});
    pulse_start();
    send_byte(8'h05, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_byte(wq[i][15:8], 1'b0);
      send_byte(wq[i][7:0], 1'b0);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_zero("midrst");
    chk("midrst_writes", exp_q.size(), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wq = '{16'h5566};
    run_load(8'h01, 1'b0, 1'b0, 1'b0);
    chk("mem0_after_rst", {16'd0, mem_img[0]}, 32'h5566);
    chk("mem1_kept", {16'd0, mem_img[1]}, {16'd0, wq.size() == 1 ?
        mem_img[1] : 16'h0000});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
